sram_block_copy: RTL and testbench

DMA requester that copies a block of 32-bit words from one SRAM word address to another, through the memory controller's two-bit `mem_op` / `mem_opdone` request interface. It issues one read, then one write per word, and waits for the controller's `mem_opdone` pulse on each access. A per-access watchdog flags a stalled controller. It connects to the controller as an additional DMA client, alongside the matrix multiplication and convolution cores, and is started by a control register write from the Wishbone side.

---
 rtl/sram_block_copy.sv | 214 +++++++++++++++++++++
 tb/tb_sram_block_copy.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_block_copy.sv
// -----------------------------------------------------------------------------
// sram_block_copy
//   DMA client that copies `length` 32-bit words from SRAM word address
//   `src_addr` to `dst_addr` through the controller's mem_op/mem_opdone
//   handshake. Each word is one read followed by one write. Each access is
//   guarded by a watchdog. The watchdog ends the copy with a sticky `error`
//   if the controller does not answer within TIMEOUT cycles.
//
// Ports
//   clk, reset      : clock and synchronous active-high reset
//   start           : one-cycle pulse; accepted only while idle
//   src_addr        : first source word address (AWIDTH)
//   dst_addr        : first destination word address (AWIDTH)
//   length          : number of words to copy (LWIDTH)
//   busy            : copy in progress
//   done            : one-cycle end-of-copy pulse (also on error and length 0)
//   error           : sticky watchdog flag, cleared by the next accepted start
//   mem_op          : 00 none, 01 read, 11 write
//   mem_addr        : word address of the current request
//   mem_data        : write data of the current request
//   mem_rdata       : read data, valid while mem_opdone = 1
//   mem_opdone      : one-cycle completion pulse from the controller
// -----------------------------------------------------------------------------
module sram_block_copy #(
    parameter int AWIDTH  = 9,
    parameter int LWIDTH  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] src_addr,
    input  logic [AWIDTH-1:0] dst_addr,
    input  logic [LWIDTH-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        mem_op,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [31:0]       mem_data,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_opdone
);

    // The watchdog counter is at least 8 bits wide and is widened for larger TIMEOUT values.
    localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RGAP,
        WRITE,
        WGAP,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] src_q, src_d;
    logic [AWIDTH-1:0] dst_q, dst_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic [LWIDTH-1:0] idx_q, idx_d;
    logic [WDW-1:0]    wd_q, wd_d;
    logic [1:0]        mem_op_q, mem_op_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    // The word index wraps into the address width, so src+idx and dst+idx
    // roll over past the top of SRAM.
    logic [AWIDTH-1:0] idx_a;
    assign idx_a = AWIDTH'(idx_q);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        idx_d      = idx_q;
        wd_d       = wd_q;
        mem_op_d   = mem_op_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = length;
                    idx_d   = '0;
                    wd_d    = '0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    if (length == '0) begin
                        state_d = DONE;
                    end else begin
                        // The first read is issued on the same edge that accepts start.
                        state_d    = READ;
                        mem_op_d   = OP_READ;
                        mem_addr_d = src_addr;
                    end
                end
            end

            READ: begin
                if (mem_opdone) begin
                    mem_data_d = mem_rdata;
                    mem_op_d   = OP_NONE;
                    state_d    = RGAP;
                end else if (wd_q == WD_LAST) begin
                    error_d  = 1'b1;
                    mem_op_d = OP_NONE;
                    state_d  = DONE;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end

            // This gap cycle lets the controller clear opdone before the next request.
            RGAP: begin
                state_d    = WRITE;
                mem_op_d   = OP_WRITE;
                mem_addr_d = dst_q + idx_a;
                wd_d       = '0;
            end

            WRITE: begin
                if (mem_opdone) begin
                    mem_op_d = OP_NONE;
                    idx_d    = idx_q + LWIDTH'(1);
                    state_d  = WGAP;
                end else if (wd_q == WD_LAST) begin
                    error_d  = 1'b1;
                    mem_op_d = OP_NONE;
                    state_d  = DONE;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end

            WGAP: begin
                if (idx_q == len_q) begin
                    state_d = DONE;
                end else begin
                    state_d    = READ;
                    mem_op_d   = OP_READ;
                    mem_addr_d = src_q + idx_a;
                    wd_d       = '0;
                end
            end

            DONE: begin
                // done rises on the same edge on which busy falls, as the state leaves DONE.
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                mem_op_d = OP_NONE;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            wd_q       <= '0;
            mem_op_q   <= OP_NONE;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            wd_q       <= wd_d;
            mem_op_q   <= mem_op_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign mem_op   = mem_op_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

endmodule

// File: tb/tb_sram_block_copy.sv
// -----------------------------------------------------------------------------
// tb_sram_block_copy
//   Directed bench for sram_block_copy. A behavioural controller answers each
//   request after L = 2 cycles. It can be told to withhold the answer for one
//   read address. Cycle numbers in the comments count from the first cycle
//   after the edge that samples start (cycle 1 = first request visible).
// -----------------------------------------------------------------------------
module tb_sram_block_copy;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  src_addr;
    logic [8:0]  dst_addr;
    logic [9:0]  length;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  mem_op;
    logic [8:0]  mem_addr;
    logic [31:0] mem_data;
    logic [31:0] mem_rdata  = 32'h0;
    logic        mem_opdone = 1'b0;

    int checks   = 0;
    int failures = 0;

    sram_block_copy #(.AWIDTH(9), .LWIDTH(10), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_rdata  (mem_rdata),
        .mem_opdone (mem_opdone)
    );

    always #5 clk = ~clk;

    // ---------------- controller / SRAM model ----------------
    logic [31:0] sram [0:511];
    logic [1:0]  log_op [$];
    logic [8:0]  log_addr [$];
    int          age = 0;
    logic        cur_stall = 1'b0;
    logic        stall_en = 1'b0;
    logic [8:0]  stall_addr = 9'h0;

    // The model acts on the negative edge, so its opdone is stable at the DUT's sampling edge.
    always @(negedge clk) begin
        mem_opdone = 1'b0;
        if (mem_op == 2'b00) begin
            age = 0;
        end else begin
            age++;
            if (age == 1) begin
                log_op.push_back(mem_op);
                log_addr.push_back(mem_addr);
                cur_stall = stall_en && mem_op == 2'b01 && mem_addr == stall_addr;
            end
            if (age == L && !cur_stall) begin
                mem_opdone = 1'b1;
                if (mem_op == 2'b01) mem_rdata = sram[mem_addr];
                else                 sram[mem_addr] = mem_data;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // The task is called at a negedge and returns at the negedge of cycle 1.
    task automatic do_start(input logic [8:0] s, input logic [8:0] d, input logic [9:0] n);
        start = 1'b1; src_addr = s; dst_addr = d; length = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_op"},    32'(mem_op),   32'h0);
        chk({pfx, "_addr"},  32'(mem_addr), 32'h0);
        chk({pfx, "_data"},  mem_data,      32'h0);
        chk({pfx, "_busy"},  32'(busy),     32'h0);
        chk({pfx, "_done"},  32'(done),     32'h0);
        chk({pfx, "_error"}, 32'(error),    32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        int base;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        for (int i = 0; i < 512; i++) sram[i] = 32'h0;
        repeat (3) tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick();

        // 1) basic copy: 4 words 0x010 -> 0x080. The per-word cost is 2L+2 = 6 cycles.
        //    The last WGAP is cycle 24, DONE is cycle 25 and done is visible in cycle 26.
        for (int i = 0; i < 4; i++) sram[16 + i] = 32'hA0 + 32'(i);
        base = log_op.size();
        do_start(9'h010, 9'h080, 10'd4);
        chk("t1_first_op",   32'(mem_op),   32'h1);
        chk("t1_first_addr", 32'(mem_addr), 32'h010);
        chk("t1_busy",       32'(busy),     32'h1);
        wait_done(60, cnt);
        chk("t1_done_lat",   32'(cnt),      32'd25);
        chk("t1_busy_fall",  32'(busy),     32'h0);
        tick();
        chk("t1_done_pulse", 32'(done),     32'h0);
        chk("t1_nreq", 32'(log_op.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_op%0d", i), 32'(log_op[base + i]), (i % 2) ? 32'h3 : 32'h1);
            chk($sformatf("t1_ad%0d", i), 32'(log_addr[base + i]),
                (i % 2) ? 32'h080 + 32'(i / 2) : 32'h010 + 32'(i / 2));
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("t1_dst%0d", i), sram[128 + i], 32'hA0 + 32'(i));

        // 2) zero length: done is visible two cycles after start, with no requests.
        base = log_op.size();
        do_start(9'h030, 9'h090, 10'd0);
        chk("t2_busy",  32'(busy),   32'h1);
        chk("t2_op",    32'(mem_op), 32'h0);
        chk("t2_done0", 32'(done),   32'h0);
        tick();
        chk("t2_done",  32'(done),   32'h1);
        chk("t2_busy0", 32'(busy),   32'h0);
        chk("t2_error", 32'(error),  32'h0);
        chk("t2_op2",   32'(mem_op), 32'h0);
        chk("t2_nreq",  32'(log_op.size() - base), 32'd0);

        // 3) wrap-around: the source reads are 0x1FE, 0x1FF and then 0x000.
        sram[9'h1FE] = 32'h11; sram[9'h1FF] = 32'h22; sram[0] = 32'h33;
        base = log_op.size();
        do_start(9'h1FE, 9'h020, 10'd3);
        wait_done(60, cnt);
        chk("t3_done_lat", 32'(cnt), 32'd19);
        chk("t3_rd0", 32'(log_addr[base + 0]), 32'h1FE);
        chk("t3_rd1", 32'(log_addr[base + 2]), 32'h1FF);
        chk("t3_rd2", 32'(log_addr[base + 4]), 32'h000);
        chk("t3_dst0", sram[9'h020], 32'h11);
        chk("t3_dst1", sram[9'h021], 32'h22);
        chk("t3_dst2", sram[9'h022], 32'h33);

        // 4) timeout: the second read (address 0x041) is never answered. It is
        //    issued in cycle 7, waits 16 cycles, and error is set in cycle 23.
        for (int i = 0; i < 3; i++) begin
            sram[64 + i]  = 32'hB0 + 32'(i);
            sram[192 + i] = 32'hDEAD;
        end
        stall_addr = 9'h041; stall_en = 1'b1;
        do_start(9'h040, 9'h0C0, 10'd3);
        cnt = 0;
        while (error !== 1'b1 && cnt < 60) begin
            tick();
            cnt++;
        end
        chk("t4_err_lat", 32'(cnt),    32'd22);
        chk("t4_op",      32'(mem_op), 32'h0);
        chk("t4_done0",   32'(done),   32'h0);
        tick();
        chk("t4_done",    32'(done),   32'h1);
        chk("t4_err",     32'(error),  32'h1);
        chk("t4_busy",    32'(busy),   32'h0);
        chk("t4_dst0", sram[9'h0C0], 32'hB0);
        chk("t4_dst1", sram[9'h0C1], 32'hDEAD);
        chk("t4_dst2", sram[9'h0C2], 32'hDEAD);
        stall_en = 1'b0;
        tick();
        chk("t4_sticky",  32'(error),  32'h1);
        do_start(9'h041, 9'h0C1, 10'd1);
        chk("t4_err_clr", 32'(error),  32'h0);
        wait_done(30, cnt);
        chk("t4_retry_lat", 32'(cnt),  32'd7);
        chk("t4_retry_dst", sram[9'h0C1], 32'hB1);

        // 5) A second start pulse while busy is ignored.
        sram[9'h100] = 32'hC0; sram[9'h101] = 32'hC1;
        base = log_op.size();
        do_start(9'h100, 9'h140, 10'd2);
        tick(); tick();
        start = 1'b1; src_addr = 9'h180; dst_addr = 9'h1C0; length = 10'd5;
        tick();
        start = 1'b0;
        wait_done(60, cnt);
        chk("t5_done_lat", 32'(cnt), 32'd10);
        chk("t5_nreq", 32'(log_op.size() - base), 32'd4);
        chk("t5_a0", 32'(log_addr[base + 0]), 32'h100);
        chk("t5_a1", 32'(log_addr[base + 1]), 32'h140);
        chk("t5_a2", 32'(log_addr[base + 2]), 32'h101);
        chk("t5_a3", 32'(log_addr[base + 3]), 32'h141);
        chk("t5_dst0", sram[9'h140], 32'hC0);
        chk("t5_dst1", sram[9'h141], 32'hC1);

        // 6) reset during the first WRITE (cycle 4), then a clean copy.
        do_start(9'h000, 9'h0E0, 10'd4);
        cnt = 0;
        while (mem_op !== 2'b11 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("t6_write_at", 32'(cnt), 32'd3);
        reset = 1'b1;
        tick();
        chk_reset_vals("t6");
        reset = 1'b0;
        tick();
        chk("t6_idle_busy", 32'(busy), 32'h0);
        do_start(9'h010, 9'h0F0, 10'd1);
        chk("t6_op",   32'(mem_op),   32'h1);
        chk("t6_addr", 32'(mem_addr), 32'h010);
        wait_done(30, cnt);
        chk("t6_done_lat", 32'(cnt), 32'd7);
        chk("t6_dst", sram[9'h0F0], 32'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
